// File: rtl/rammodel_frontend.sv
// AXI4-slave timing front end of the emulated RAM: forwards every address, W beat
// and B/R completion to the storage back end and releases B/R after fixed latencies.
module rammodel_frontend #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int R_DELAY      = 25,
  parameter int W_DELAY      = 3
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    target_axi_awvalid,
  output logic                    target_axi_awready,
  input  logic [ID_WIDTH-1:0]     target_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   target_axi_awaddr,
  input  logic [7:0]              target_axi_awlen,
  input  logic [2:0]              target_axi_awsize,
  input  logic [1:0]              target_axi_awburst,

  input  logic                    target_axi_wvalid,
  output logic                    target_axi_wready,
  input  logic [DATA_WIDTH-1:0]   target_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] target_axi_wstrb,
  input  logic                    target_axi_wlast,

  output logic                    target_axi_bvalid,
  input  logic                    target_axi_bready,
  output logic [ID_WIDTH-1:0]     target_axi_bid,
  output logic [1:0]              target_axi_bresp,

  input  logic                    target_axi_arvalid,
  output logic                    target_axi_arready,
  input  logic [ID_WIDTH-1:0]     target_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   target_axi_araddr,
  input  logic [7:0]              target_axi_arlen,
  input  logic [2:0]              target_axi_arsize,
  input  logic [1:0]              target_axi_arburst,

  output logic                    target_axi_rvalid,
  input  logic                    target_axi_rready,
  output logic [ID_WIDTH-1:0]     target_axi_rid,
  output logic [DATA_WIDTH-1:0]   target_axi_rdata,
  output logic [1:0]              target_axi_rresp,
  output logic                    target_axi_rlast,

  output logic                    areq_valid,
  output logic                    areq_write,
  output logic [ID_WIDTH-1:0]     areq_id,
  output logic [ADDR_WIDTH-1:0]   areq_addr,
  output logic [7:0]              areq_len,
  output logic [2:0]              areq_size,
  output logic [1:0]              areq_burst,

  output logic                    wreq_valid,
  output logic [DATA_WIDTH-1:0]   wreq_data,
  output logic [DATA_WIDTH/8-1:0] wreq_strb,
  output logic                    wreq_last,

  output logic                    breq_valid,
  output logic [ID_WIDTH-1:0]     breq_id,

  output logic                    rreq_valid,
  output logic [ID_WIDTH-1:0]     rreq_id,

  input  logic [DATA_WIDTH-1:0]   rresp_data,
  input  logic                    rresp_last
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] FULL  = CW'(MAX_INFLIGHT);
  localparam logic [15:0]   R_LAT = 16'(R_DELAY);
  localparam logic [15:0]   W_LAT = 16'(W_DELAY);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Free-running cycle counter used for latency stamps; ages use modulo subtraction.
  logic [15:0]         cnt_q, cnt_d;

  // Write timing FIFO. wr_sptr points at the oldest entry still waiting for WLAST.
  logic [ID_WIDTH-1:0] wr_id_q    [MAX_INFLIGHT];
  logic [15:0]         wr_stamp_q [MAX_INFLIGHT];
  logic [PW-1:0]       wr_head_q, wr_head_d;
  logic [PW-1:0]       wr_tail_q, wr_tail_d;
  logic [PW-1:0]       wr_sptr_q, wr_sptr_d;
  logic [CW-1:0]       wr_out_q, wr_out_d;
  logic [CW-1:0]       w_pend_q, w_pend_d;

  // Read timing FIFO.
  logic [ID_WIDTH-1:0] rd_id_q    [MAX_INFLIGHT];
  logic [15:0]         rd_stamp_q [MAX_INFLIGHT];
  logic [PW-1:0]       rd_head_q, rd_head_d;
  logic [PW-1:0]       rd_tail_q, rd_tail_d;
  logic [CW-1:0]       rd_out_q, rd_out_d;

  logic        aw_hs, ar_hs, w_hs, wlast_hs, b_hs, r_hs, r_pop;
  logic [15:0] w_age, r_age;

  // Handshakes; AW wins the single areq slot over AR.
  assign target_axi_awready = !rst && (wr_out_q < FULL);
  assign aw_hs              = target_axi_awvalid && target_axi_awready;
  assign target_axi_arready = !rst && (rd_out_q < FULL) && !aw_hs;
  assign ar_hs              = target_axi_arvalid && target_axi_arready;
  assign target_axi_wready  = !rst && (w_pend_q != '0);
  assign w_hs               = target_axi_wvalid && target_axi_wready;
  assign wlast_hs           = w_hs && target_axi_wlast;

  assign areq_valid = aw_hs || ar_hs;
  assign areq_write = aw_hs;
  assign areq_id    = aw_hs ? target_axi_awid    : target_axi_arid;
  assign areq_addr  = aw_hs ? target_axi_awaddr  : target_axi_araddr;
  assign areq_len   = aw_hs ? target_axi_awlen   : target_axi_arlen;
  assign areq_size  = aw_hs ? target_axi_awsize  : target_axi_arsize;
  assign areq_burst = aw_hs ? target_axi_awburst : target_axi_arburst;

  assign wreq_valid = w_hs;
  assign wreq_data  = target_axi_wdata;
  assign wreq_strb  = target_axi_wstrb;
  assign wreq_last  = target_axi_wlast;

  // The head is stamped exactly when it is older than every still-pending AW.
  assign w_age             = cnt_q - wr_stamp_q[wr_head_q];
  assign target_axi_bvalid = !rst && (wr_out_q > w_pend_q) && (w_age >= W_LAT);
  assign target_axi_bid    = wr_id_q[wr_head_q];
  assign target_axi_bresp  = 2'b00;
  assign b_hs              = target_axi_bvalid && target_axi_bready;
  assign breq_valid        = b_hs;
  assign breq_id           = target_axi_bid;

  assign r_age             = cnt_q - rd_stamp_q[rd_head_q];
  assign target_axi_rvalid = !rst && (rd_out_q != '0) && (r_age >= R_LAT);
  assign target_axi_rid    = rd_id_q[rd_head_q];
  assign target_axi_rdata  = rresp_data;
  assign target_axi_rlast  = rresp_last;
  assign target_axi_rresp  = 2'b00;
  assign r_hs              = target_axi_rvalid && target_axi_rready;
  assign r_pop             = r_hs && rresp_last;
  assign rreq_valid        = r_hs;
  assign rreq_id           = target_axi_rid;

  // NOTE: every _d is given its hold value first, so no path can infer a latch.
  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    wr_head_d = wr_head_q;
    wr_tail_d = wr_tail_q;
    wr_sptr_d = wr_sptr_q;
    wr_out_d  = wr_out_q;
    w_pend_d  = w_pend_q;
    rd_head_d = rd_head_q;
    rd_tail_d = rd_tail_q;
    rd_out_d  = rd_out_q;

    if (aw_hs)    wr_tail_d = ptr_inc(wr_tail_q);
    if (wlast_hs) wr_sptr_d = ptr_inc(wr_sptr_q);
    if (b_hs)     wr_head_d = ptr_inc(wr_head_q);
    if (ar_hs)    rd_tail_d = ptr_inc(rd_tail_q);
    if (r_pop)    rd_head_d = ptr_inc(rd_head_q);

    case ({aw_hs, b_hs})
      2'b10:   wr_out_d = wr_out_q + CW'(1);
      2'b01:   wr_out_d = wr_out_q - CW'(1);
      default: wr_out_d = wr_out_q;
    endcase

    case ({aw_hs, wlast_hs})
      2'b10:   w_pend_d = w_pend_q + CW'(1);
      2'b01:   w_pend_d = w_pend_q - CW'(1);
      default: w_pend_d = w_pend_q;
    endcase

    case ({ar_hs, r_pop})
      2'b10:   rd_out_d = rd_out_q + CW'(1);
      2'b01:   rd_out_d = rd_out_q - CW'(1);
      default: rd_out_d = rd_out_q;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_head_q <= '0;
      wr_tail_q <= '0;
      wr_sptr_q <= '0;
      wr_out_q  <= '0;
      w_pend_q  <= '0;
      rd_head_q <= '0;
      rd_tail_q <= '0;
      rd_out_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_head_q <= wr_head_d;
      wr_tail_q <= wr_tail_d;
      wr_sptr_q <= wr_sptr_d;
      wr_out_q  <= wr_out_d;
      w_pend_q  <= w_pend_d;
      rd_head_q <= rd_head_d;
      rd_tail_q <= rd_tail_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy counters mask any stale entry.
  always_ff @(posedge clk) begin
    if (aw_hs) wr_id_q[wr_tail_q] <= target_axi_awid;
    if (wlast_hs) wr_stamp_q[wr_sptr_q] <= cnt_q;
    if (ar_hs) begin
      rd_id_q[rd_tail_q]    <= target_axi_arid;
      rd_stamp_q[rd_tail_q] <= cnt_q;
    end
  end

endmodule

// File: tb/tb_rammodel_frontend.sv
// Randomised bench for rammodel_frontend: a queue-based model of the AXI timing rules
// is compared every cycle, and directed scenarios pin the model with literal values.
module tb_rammodel_frontend;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int MAXI = 8;
  localparam int RD   = 25;
  localparam int WD   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic          areq_valid, areq_write, wreq_valid, wreq_last, breq_valid, rreq_valid;
  logic [IW-1:0] areq_id, breq_id, rreq_id;
  logic [AW-1:0] areq_addr;
  logic [7:0]    areq_len;
  logic [2:0]    areq_size;
  logic [1:0]    areq_burst;
  logic [DW-1:0] wreq_data, rresp_data;
  logic [DW/8-1:0] wreq_strb;
  logic          rresp_last;

  rammodel_frontend #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MAX_INFLIGHT(MAXI), .R_DELAY(RD), .W_DELAY(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .target_axi_awvalid(awvalid), .target_axi_awready(awready), .target_axi_awid(awid),
    .target_axi_awaddr(awaddr), .target_axi_awlen(awlen), .target_axi_awsize(awsize),
    .target_axi_awburst(awburst),
    .target_axi_wvalid(wvalid), .target_axi_wready(wready), .target_axi_wdata(wdata),
    .target_axi_wstrb(wstrb), .target_axi_wlast(wlast),
    .target_axi_bvalid(bvalid), .target_axi_bready(bready), .target_axi_bid(bid),
    .target_axi_bresp(bresp),
    .target_axi_arvalid(arvalid), .target_axi_arready(arready), .target_axi_arid(arid),
    .target_axi_araddr(araddr), .target_axi_arlen(arlen), .target_axi_arsize(arsize),
    .target_axi_arburst(arburst),
    .target_axi_rvalid(rvalid), .target_axi_rready(rready), .target_axi_rid(rid),
    .target_axi_rdata(rdata), .target_axi_rresp(rresp), .target_axi_rlast(rlast),
    .areq_valid(areq_valid), .areq_write(areq_write), .areq_id(areq_id),
    .areq_addr(areq_addr), .areq_len(areq_len), .areq_size(areq_size),
    .areq_burst(areq_burst),
    .wreq_valid(wreq_valid), .wreq_data(wreq_data), .wreq_strb(wreq_strb),
    .wreq_last(wreq_last),
    .breq_valid(breq_valid), .breq_id(breq_id),
    .rreq_valid(rreq_valid), .rreq_id(rreq_id),
    .rresp_data(rresp_data), .rresp_last(rresp_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [IW-1:0] id; int done; } wm_t;
  typedef struct { logic [IW-1:0] id; int acc;  } rm_t;
  typedef struct { logic [DW-1:0] data; logic last; } bb_t;

  wm_t wq[$];   // accepted writes, done = edge of WLAST or -1
  rm_t rq[$];   // accepted reads, acc = edge of AR acceptance
  bb_t bq[$];   // back-end read beats in order
  int  cyc = 0; // index of the upcoming clock edge

  always @(negedge clk) begin : model_cmp
    int  unst;
    logic e_awr, e_arr, e_wr, e_bv, e_rv;
    logic e_awhs, e_arhs, e_whs, e_bhs, e_rhs;
    bb_t hb;
    wm_t wt;
    rm_t rt;
    bb_t nb;
    unst = 0;
    foreach (wq[i]) if (wq[i].done < 0) unst++;
    hb.data = '0;
    hb.last = 1'b0;
    if (bq.size() > 0) hb = bq[0];

    e_awr  = !rst && (wq.size() < MAXI);
    e_awhs = awvalid && e_awr;
    e_arr  = !rst && (rq.size() < MAXI) && !e_awhs;
    e_arhs = arvalid && e_arr;
    e_wr   = !rst && (unst > 0);
    e_whs  = wvalid && e_wr;
    e_bv   = !rst && (wq.size() > 0) && (wq[0].done >= 0) && (cyc - wq[0].done >= WD);
    e_bhs  = e_bv && bready;
    e_rv   = !rst && (rq.size() > 0) && (cyc - rq[0].acc >= RD);
    e_rhs  = e_rv && rready;

    check("readys", {awready, arready, wready}, {e_awr, e_arr, e_wr});
    check("valids", {bvalid, rvalid, areq_valid, wreq_valid, breq_valid, rreq_valid},
          {e_bv, e_rv, e_awhs || e_arhs, e_whs, e_bhs, e_rhs});
    if (e_awhs)
      check("areq_aw", {areq_write, areq_id, areq_addr, areq_len, areq_size, areq_burst},
            {1'b1, awid, awaddr, awlen, awsize, awburst});
    else if (e_arhs)
      check("areq_ar", {areq_write, areq_id, areq_addr, areq_len, areq_size, areq_burst},
            {1'b0, arid, araddr, arlen, arsize, arburst});
    if (e_whs) check("wreq", {wreq_data, wreq_strb, wreq_last}, {wdata, wstrb, wlast});
    if (e_bv)  check("b_payload", {bid, bresp}, {wq[0].id, 2'b00});
    if (e_bhs) check("breq_id", breq_id, wq[0].id);
    if (e_rv)  check("r_payload", {rid, rdata, rlast, rresp}, {rq[0].id, hb.data, hb.last, 2'b00});
    if (e_rhs) check("rreq_id", rreq_id, rq[0].id);

    if (rst) begin
      wq.delete();
      rq.delete();
      bq.delete();
    end else begin
      if (e_whs && wlast) begin
        for (int i = 0; i < wq.size(); i++) begin
          if (wq[i].done < 0) begin
            wt = wq[i];
            wt.done = cyc;
            wq[i] = wt;
            break;
          end
        end
      end
      if (e_bhs) void'(wq.pop_front());
      if (e_awhs) begin
        wt.id = awid;
        wt.done = -1;
        wq.push_back(wt);
      end
      if (e_rhs) begin
        void'(bq.pop_front());
        if (hb.last) void'(rq.pop_front());
      end
      if (e_arhs) begin
        rt.id = arid;
        rt.acc = cyc;
        rq.push_back(rt);
        for (int b = 0; b <= int'(arlen); b++) begin
          nb.data = {$urandom(), $urandom()};
          nb.last = (b == int'(arlen));
          bq.push_back(nb);
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ax_t;
  typedef struct { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } wb_t;

  ax_t aw_todo[$];
  ax_t ar_todo[$];
  wb_t w_todo[$];
  logic aw_en = 1'b1, ar_en = 1'b1, w_en = 1'b1;
  logic rnd = 1'b0, b_rdy = 1'b1, r_rdy = 1'b1;

  logic s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast;
  logic s_areq_valid, s_areq_write, s_wreq_valid, s_breq_valid, s_rreq_valid;
  logic [IW-1:0] s_rid, s_bid, s_breq_id, s_rreq_id;
  logic s_aw_hs, s_ar_hs, s_w_hs, s_wlast_hs, s_b_hs, s_r_hs;

  task automatic enq_write(input logic [IW-1:0] id, input int len);
    ax_t t;
    wb_t w;
    t.id = id; t.addr = $urandom(); t.len = 8'(len);
    aw_todo.push_back(t);
    for (int b = 0; b <= len; b++) begin
      w.data = {$urandom(), $urandom()};
      w.strb = 8'($urandom_range(255));
      w.last = (b == len);
      w_todo.push_back(w);
    end
  endtask

  task automatic enq_read(input logic [IW-1:0] id, input int len);
    ax_t t;
    t.id = id; t.addr = $urandom(); t.len = 8'(len);
    ar_todo.push_back(t);
  endtask

  // Sample outputs before the edge, then update drivers just after it.
  task automatic step();
    ax_t t;
    wb_t w;
    @(negedge clk);
    s_awready = awready; s_arready = arready; s_wready = wready;
    s_bvalid = bvalid; s_rvalid = rvalid; s_rlast = rlast; s_rid = rid; s_bid = bid;
    s_areq_valid = areq_valid; s_areq_write = areq_write; s_wreq_valid = wreq_valid;
    s_breq_valid = breq_valid; s_breq_id = breq_id;
    s_rreq_valid = rreq_valid; s_rreq_id = rreq_id;
    s_aw_hs = awvalid && awready; s_ar_hs = arvalid && arready;
    s_w_hs = wvalid && wready; s_wlast_hs = s_w_hs && wlast;
    s_b_hs = bvalid && bready; s_r_hs = rvalid && rready;
    @(posedge clk);
    #1;
    if (s_aw_hs) awvalid = 1'b0;
    if (s_ar_hs) arvalid = 1'b0;
    if (s_w_hs)  wvalid  = 1'b0;
    if (!awvalid && aw_en && aw_todo.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
      t = aw_todo.pop_front();
      awvalid = 1'b1; awid = t.id; awaddr = t.addr; awlen = t.len;
      awsize = 3'd3; awburst = 2'd1;
    end
    if (!arvalid && ar_en && ar_todo.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
      t = ar_todo.pop_front();
      arvalid = 1'b1; arid = t.id; araddr = t.addr; arlen = t.len;
      arsize = 3'd3; arburst = 2'd1;
    end
    if (!wvalid && w_en && w_todo.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
      w = w_todo.pop_front();
      wvalid = 1'b1; wdata = w.data; wstrb = w.strb; wlast = w.last;
    end
    bready = rnd ? 1'($urandom_range(1)) : b_rdy;
    rready = rnd ? 1'($urandom_range(1)) : r_rdy;
    if (bq.size() > 0) begin
      rresp_data = bq[0].data;
      rresp_last = bq[0].last;
    end else begin
      rresp_data = '0;
      rresp_last = 1'b0;
    end
  endtask

  task automatic clear_drivers();
    aw_todo.delete(); ar_todo.delete(); w_todo.delete();
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int k, nw, nwreq, nacc;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    bready = 1; rready = 1; rresp_data = '0; rresp_last = 0;

    rst = 1'b1;
    run(4);
    check("reset_outputs", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_areq_valid}, 6'b0);
    rst = 1'b0;

    // Single read, len=0, id=3
    enq_read(4'd3, 0);
    k = 0;
    do begin step(); k++; end while (!s_ar_hs && k < 20);
    check("rd_ar_accepted", s_ar_hs, 1'b1);
    check("rd_areq", {s_areq_valid, s_areq_write}, 2'b10);
    k = 0;
    do begin step(); k++; end while (!s_rvalid && k < 100);
    check("rd_latency", 128'(k), 128'(25));
    check("rd_first_beat", {s_rid, s_rlast, s_rreq_valid, s_rreq_id}, {4'd3, 1'b1, 1'b1, 4'd3});
    run(3);

    // Single write, len=3, id=5
    enq_write(4'd5, 3);
    k = 0;
    do begin step(); k++; end while (!s_aw_hs && k < 20);
    check("wr_areq", {s_aw_hs, s_areq_valid, s_areq_write}, 3'b111);
    nw = 0; nwreq = 0; k = 0;
    do begin
      step(); k++;
      if (s_w_hs) nw++;
      if (s_wreq_valid) nwreq++;
    end while (!s_wlast_hs && k < 50);
    check("wr_beats", 128'(nw), 128'(4));
    check("wr_wreq_pulses", 128'(nwreq), 128'(4));
    k = 0;
    do begin step(); k++; end while (!s_bvalid && k < 50);
    check("wr_latency", 128'(k), 128'(3));
    check("wr_b", {s_bid, s_breq_valid, s_breq_id}, {4'd5, 1'b1, 4'd5});
    run(3);

    // AW and AR presented in the same cycle
    enq_write(4'd9, 0);
    enq_read(4'd10, 0);
    k = 0;
    do begin step(); k++; end while (!s_aw_hs && k < 20);
    check("aw_over_ar", {s_aw_hs, s_ar_hs, s_arready, s_areq_write}, 4'b1001);
    step();
    check("ar_next_cycle", {s_ar_hs, s_areq_valid, s_areq_write}, 3'b110);
    run(60);

    // Nine reads against eight slots
    r_rdy = 1'b0;
    for (int i = 0; i < 9; i++) enq_read(4'(i), 0);
    nacc = 0; k = 0;
    do begin step(); k++; if (s_ar_hs) nacc++; end while (nacc < 8 && k < 60);
    check("eight_accepted", 128'(nacc), 128'(8));
    run(2);
    check("ar_full", {s_arready, s_ar_hs}, 2'b00);
    k = 0;
    do begin step(); k++; end while (!s_rvalid && k < 60);
    r_rdy = 1'b1;
    k = 0;
    do begin step(); k++; end while (!s_r_hs && k < 10);
    check("first_pop_blocks_ar", {s_r_hs, s_rlast, s_ar_hs}, 3'b110);
    step();
    check("ninth_accepted", s_ar_hs, 1'b1);
    run(80);

    // W presented before AW
    aw_en = 1'b0;
    enq_write(4'd2, 1);
    run(2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("w_before_aw", {wvalid, s_wready, s_wreq_valid}, 3'b100);
    end
    aw_en = 1'b1;
    run(30);

    // Read burst len=7 with rready toggling
    enq_read(4'd6, 7);
    k = 0; nw = 0; nwreq = 0;
    do begin
      r_rdy = 1'($urandom_range(1));
      step(); k++;
      if (s_r_hs) nw++;
      if (s_rreq_valid) nwreq++;
    end while (!(s_r_hs && s_rlast) && k < 300);
    check("burst_beats", 128'(nw), 128'(8));
    check("burst_rreq", 128'(nwreq), 128'(8));
    r_rdy = 1'b1;
    run(5);

    // Reset in the middle of a read burst with writes outstanding
    b_rdy = 1'b0;
    enq_write(4'd7, 0);
    enq_read(4'd1, 7);
    k = 0;
    do begin step(); k++; end while (!s_r_hs && k < 100);
    check("burst2_started", s_r_hs, 1'b1);
    rst = 1'b1;
    clear_drivers();
    step();
    check("rst_drops_valids", {s_rvalid, s_bvalid, s_awready, s_arready, s_wready, s_areq_valid, s_rreq_valid}, 7'b0);
    step();
    rst = 1'b0;
    b_rdy = 1'b1;
    step();
    step();
    check("post_rst_idle", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 5'b11000);

    // Randomised traffic
    rnd = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (aw_todo.size() < 2 && $urandom_range(2) == 0) enq_write(4'($urandom_range(15)), $urandom_range(7));
      if (ar_todo.size() < 2 && $urandom_range(2) == 0) enq_read(4'($urandom_range(15)), $urandom_range(7));
      step();
    end
    rnd = 1'b0; b_rdy = 1'b1; r_rdy = 1'b1;
    run(500);
    check("drain_idle", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 5'b11000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
